pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised next-generation program counter for the MiniRISC core.
- Holds the fetch address and computes the next PC each cycle: sequential, branch/jump, call and return.
- Includes a small circular return-address stack (RAS), so call/return no longer need a register-file round trip.
- Sits between the branch/decode logic and instruction memory; stall input comes from the hazard unit.

Parameters:
- WIDTH, 32, PC and address width in bits.
- STEP, 1, sequential increment (1 = word-addressed instruction memory).
- RESET_VEC, 0, PC value loaded on reset.
- RAS_DEPTH, 4, return-address stack entries; power of 2, minimum 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  hold PC and RAS unchanged this cycle.
- branch_taken  input  1  load branch_target (plain jump/branch).
- call  input  1  jump to branch_target and push pc_out+STEP.
- ret  input  1  pop RAS top into PC.
- branch_target  input  WIDTH  target for branch_taken/call.
- pc_out  output  WIDTH  current fetch address (registered).
- pc_seq  output  WIDTH  combinational pc_out+STEP, the link value.
- ras_count  output  clog2(RAS_DEPTH)+1  valid RAS entries.
- ras_empty  output  1  ras_count==0.
- ras_full  output  1  ras_count==RAS_DEPTH.
- ras_overflow  output  1  sticky: a push occurred while full.
- ras_underflow  output  1  sticky: a pop occurred while empty.

Behaviour:
- Reset (clk edge with rst=1):
  - pc_out=RESET_VEC, ras_count=0, stack pointer=0.
  - ras_overflow=0, ras_underflow=0.
  - RAS contents are don't-care.
  - rst overrides every other input.
- All arithmetic is modulo 2^WIDTH. pc_out=2^WIDTH-STEP with no redirect gives next pc_out=0, no flag.
- Next-PC priority, evaluated per cycle when rst=0:
  1. stall=1: pc_out, RAS and flags hold. All other inputs are ignored.
  2. ret=1 and call=1 (tail call): pc_out<=branch_target. The RAS top entry is replaced with pc_seq and ras_count is unchanged. If the RAS is empty, the access is a plain push, count becomes 1 and ras_underflow is set.
  3. ret=1 only:
     - Not empty: pc_out<=top entry, pointer decrements, count decrements.
     - Empty: pc_out<=pc_seq, ras_underflow<=1, count stays 0.
  4. call=1 only: pc_out<=branch_target and pc_seq is pushed.
     - Not full: count increments.
     - Full: the oldest entry is overwritten (circular pointer wraps), count stays RAS_DEPTH, ras_overflow<=1.
  5. branch_taken=1: pc_out<=branch_target. RAS untouched.
  6. Otherwise: pc_out<=pc_seq.
- branch_taken is ignored whenever call or ret is asserted.
- RAS is a circular buffer:
  - Write pointer of clog2(RAS_DEPTH) bits, wrapping modulo RAS_DEPTH.
  - Top = pointer-1 (mod RAS_DEPTH).
  - Push writes at pointer then increments; pop decrements.
- Latency: redirect inputs sampled at edge N appear on pc_out after edge N (one cycle). pc_seq tracks pc_out combinationally.
- Sticky flags clear only on rst.
- Reset asserted mid-sequence (e.g. during call/ret) discards that operation entirely.

Test Plan:
- Reset then free-run, WIDTH=32, STEP=1, RESET_VEC=0x100 -> pc_out 0x100, 0x101, 0x102...; ras_empty=1, flags 0.
- Wrap: WIDTH=8, STEP=4, force pc_out=0xFC -> next 0x00, no flag. Stall 3 cycles at 0x40 -> pc_out holds 0x40; branch_taken with stall -> ignored.
- Nested calls:
  - At pc 0x10 call 0x80 -> pc 0x80, count 1.
  - At 0x85 call 0xC0 -> count 2.
  - ret -> 0x86.
  - ret -> 0x11, ras_empty=1.
- Overflow, RAS_DEPTH=4: 5 calls from pcs 0x0,0x20,0x40,0x60,0x80 -> count 4, ras_overflow=1. Four rets return 0x81, 0x61, 0x41, 0x21. A fifth ret sets ras_underflow=1 and pc=pc_seq.
- Tail call: count 1 holding 0x11; at pc 0x50 assert call+ret target 0x90 -> pc 0x90, count 1. Next ret -> 0x51.
- Reset mid-operation: assert rst together with call -> pc_out=RESET_VEC, count 0, flags cleared, no push.

Source files
------------

// File: rtl/pc_unit.sv
// ----------------------------------------------------------------------------
// pc_unit
//
// Program counter for the MiniRISC core with a small circular return-address
// stack (RAS). It holds the fetch address and picks the next one each cycle.
// The choices are sequential, branch/jump, call, return and tail call (call
// and ret together).
//
// Ports:
//   clk            system clock, all state updates on the rising edge
//   rst            synchronous active-high reset, overrides every other input
//   stall          hold PC, RAS and flags this cycle
//   branch_taken   load branch_target (ignored while call or ret is high)
//   call           jump to branch_target and push pc_seq
//   ret            pop the RAS top into the PC
//   branch_target  target address for branch_taken / call
//   pc_out         registered fetch address
//   pc_seq         pc_out + STEP, combinational (the link value)
//   ras_count      number of valid RAS entries
//   ras_empty      ras_count == 0
//   ras_full       ras_count == RAS_DEPTH
//   ras_overflow   sticky, set when a push happens while the RAS is full
//   ras_underflow  sticky, set when a pop happens while the RAS is empty
// ----------------------------------------------------------------------------
module pc_unit #(
    parameter int               WIDTH     = 32,
    parameter int               STEP      = 1,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int               RAS_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           stall,
    input  logic                           branch_taken,
    input  logic                           call,
    input  logic                           ret,
    input  logic [WIDTH-1:0]               branch_target,
    output logic [WIDTH-1:0]               pc_out,
    output logic [WIDTH-1:0]               pc_seq,
    output logic [$clog2(RAS_DEPTH):0]     ras_count,
    output logic                           ras_empty,
    output logic                           ras_full,
    output logic                           ras_overflow,
    output logic                           ras_underflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [WIDTH-1:0] STEP_V   = WIDTH'(STEP);
    localparam logic [CNT_W-1:0] DEPTH_V  = CNT_W'(RAS_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // Return-address storage. Contents are not reset; validity is tracked
    // by ras_count alone.
    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

    // Write pointer: next free slot. The top of stack sits at ptr-1. Because
    // RAS_DEPTH is a power of two, the pointer wraps by plain overflow, and
    // when the stack is full ptr points at the oldest entry. A push there
    // therefore overwrites the oldest return address.
    logic [PTR_W-1:0] ptr;
    logic [CNT_W-1:0] count;
    logic             ovf_q;
    logic             unf_q;

    logic [PTR_W-1:0] top_idx;
    logic             empty;
    logic             full;

    logic [WIDTH-1:0] next_pc;
    logic [PTR_W-1:0] next_ptr;
    logic [CNT_W-1:0] next_count;
    logic             next_ovf;
    logic             next_unf;
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;

    always_comb begin
        pc_seq  = pc_out + STEP_V;
        top_idx = ptr - PTR_ONE;
        empty   = (count == '0);
        full    = (count == DEPTH_V);
    end

    // Next-state selection. The priority order is stall, tail call, return,
    // call, branch, then sequential.
    always_comb begin
        next_pc    = pc_seq;
        next_ptr   = ptr;
        next_count = count;
        next_ovf   = ovf_q;
        next_unf   = unf_q;
        wr_en      = 1'b0;
        wr_idx     = ptr;

        if (stall) begin
            next_pc = pc_out;
        end else if (ret && call) begin
            // Tail call: the current frame's return address is replaced by
            // the new link. On an empty stack the pop half underflows, so
            // only the push half takes effect.
            next_pc = branch_target;
            wr_en   = 1'b1;
            if (empty) begin
                wr_idx     = ptr;
                next_ptr   = ptr + PTR_ONE;
                next_count = CNT_ONE;
                next_unf   = 1'b1;
            end else begin
                wr_idx = top_idx;
            end
        end else if (ret) begin
            if (empty) begin
                next_unf = 1'b1;
            end else begin
                next_pc    = ras_mem[top_idx];
                next_ptr   = top_idx;
                next_count = count - CNT_ONE;
            end
        end else if (call) begin
            next_pc  = branch_target;
            wr_en    = 1'b1;
            wr_idx   = ptr;
            next_ptr = ptr + PTR_ONE;
            if (full) begin
                next_ovf = 1'b1;
            end else begin
                next_count = count + CNT_ONE;
            end
        end else if (branch_taken) begin
            next_pc = branch_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_out <= RESET_VEC;
            ptr    <= '0;
            count  <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            pc_out <= next_pc;
            ptr    <= next_ptr;
            count  <= next_count;
            ovf_q  <= next_ovf;
            unf_q  <= next_unf;
        end
    end

    // Storage write. It is blocked during reset so that a call that arrives
    // together with rst leaves no trace.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            ras_mem[wr_idx] <= pc_seq;
        end
    end

    assign ras_count     = count;
    assign ras_empty     = empty;
    assign ras_full      = full;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // 32-bit instance: STEP=1, RESET_VEC=0x100, RAS_DEPTH=4
  logic        stall, branch_taken, call, ret;
  logic [31:0] branch_target;
  logic [31:0] pc_out, pc_seq;
  logic [2:0]  ras_count;
  logic        ras_empty, ras_full, ras_overflow, ras_underflow;

  // 8-bit instance: STEP=4, RESET_VEC=0, used for wrap and stall checks
  logic        s8_stall, s8_branch, s8_call, s8_ret;
  logic [7:0]  s8_target;
  logic [7:0]  s8_pc_out, s8_pc_seq;
  logic [2:0]  s8_count;
  logic        s8_empty, s8_full, s8_ovf, s8_unf;

  pc_unit #(.WIDTH(32), .STEP(1), .RESET_VEC(32'h100), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .call(call), .ret(ret), .branch_target(branch_target),
    .pc_out(pc_out), .pc_seq(pc_seq), .ras_count(ras_count),
    .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  pc_unit #(.WIDTH(8), .STEP(4), .RESET_VEC(8'h00), .RAS_DEPTH(4)) dut8 (
    .clk(clk), .rst(rst), .stall(s8_stall), .branch_taken(s8_branch),
    .call(s8_call), .ret(s8_ret), .branch_target(s8_target),
    .pc_out(s8_pc_out), .pc_seq(s8_pc_seq), .ras_count(s8_count),
    .ras_empty(s8_empty), .ras_full(s8_full),
    .ras_overflow(s8_ovf), .ras_underflow(s8_unf)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic        call;
    logic        ret;
    logic [31:0] tgt;
    logic [31:0] exp_pc;
    logic [2:0]  exp_cnt;
    logic        exp_ovf;
    logic        exp_unf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic s, input logic b, input logic c,
                     input logic rt, input logic [31:0] t, input logic [31:0] pc,
                     input logic [2:0] cnt, input logic ovf, input logic unf);
    vec_t v;
    v.rst = r; v.stall = s; v.br = b; v.call = c; v.ret = rt; v.tgt = t;
    v.exp_pc = pc; v.exp_cnt = cnt; v.exp_ovf = ovf; v.exp_unf = unf;
    vecs.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step8(input logic s, input logic b, input logic [7:0] t,
                       input logic [7:0] exp, input string name);
    logic [7:0] e;
    s8_stall = s; s8_branch = b; s8_target = t;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    check(name, {24'h0, s8_pc_out}, {24'h0, e});
    check({name, "_seq"}, {24'h0, s8_pc_seq}, {24'h0, e + 8'd4});
  endtask

  initial begin
    rst = 1'b1;
    stall = 0; branch_taken = 0; call = 0; ret = 0; branch_target = '0;
    s8_stall = 0; s8_branch = 0; s8_call = 0; s8_ret = 0; s8_target = '0;

    //   rst stl br cal ret target        exp_pc      cnt ovf unf
    // free run from reset vector
    add(0, 0, 0, 0, 0, 32'h0,   32'h101, 0, 0, 0);
    add(0, 0, 0, 0, 0, 32'h0,   32'h102, 0, 0, 0);
    add(0, 0, 0, 0, 0, 32'h0,   32'h103, 0, 0, 0);
    // nested calls
    add(0, 0, 1, 0, 0, 32'h10,  32'h10,  0, 0, 0);
    add(0, 0, 0, 1, 0, 32'h80,  32'h80,  1, 0, 0);
    add(0, 0, 0, 0, 0, 32'h0,   32'h81,  1, 0, 0);
    add(0, 0, 0, 0, 0, 32'h0,   32'h82,  1, 0, 0);
    add(0, 0, 0, 0, 0, 32'h0,   32'h83,  1, 0, 0);
    add(0, 0, 0, 0, 0, 32'h0,   32'h84,  1, 0, 0);
    add(0, 0, 0, 0, 0, 32'h0,   32'h85,  1, 0, 0);
    add(0, 0, 0, 1, 0, 32'hC0,  32'hC0,  2, 0, 0);
    add(0, 0, 0, 0, 1, 32'h0,   32'h86,  1, 0, 0);
    add(0, 0, 0, 0, 1, 32'h0,   32'h11,  0, 0, 0);
    // stall blocks branch and call
    add(0, 1, 1, 0, 0, 32'h40,  32'h11,  0, 0, 0);
    add(0, 1, 0, 1, 0, 32'h40,  32'h11,  0, 0, 0);
    // call wins over branch; ret on empty ignores branch and underflows
    add(0, 0, 1, 1, 0, 32'h200, 32'h200, 1, 0, 0);
    add(0, 0, 0, 0, 1, 32'h0,   32'h12,  0, 0, 0);
    add(0, 0, 1, 0, 1, 32'h300, 32'h13,  0, 0, 1);
    add(1, 0, 0, 0, 0, 32'h0,   32'h100, 0, 0, 0);
    // overflow: five calls into a 4-deep stack
    add(0, 0, 1, 0, 0, 32'h0,   32'h0,   0, 0, 0);
    add(0, 0, 0, 1, 0, 32'h20,  32'h20,  1, 0, 0);
    add(0, 0, 0, 1, 0, 32'h40,  32'h40,  2, 0, 0);
    add(0, 0, 0, 1, 0, 32'h60,  32'h60,  3, 0, 0);
    add(0, 0, 0, 1, 0, 32'h80,  32'h80,  4, 0, 0);
    add(0, 0, 0, 1, 0, 32'hA0,  32'hA0,  4, 1, 0);
    add(0, 0, 0, 0, 1, 32'h0,   32'h81,  3, 1, 0);
    add(0, 0, 0, 0, 1, 32'h0,   32'h61,  2, 1, 0);
    add(0, 0, 0, 0, 1, 32'h0,   32'h41,  1, 1, 0);
    add(0, 0, 0, 0, 1, 32'h0,   32'h21,  0, 1, 0);
    add(0, 0, 0, 0, 1, 32'h0,   32'h22,  0, 1, 1);
    // reset together with a call discards the call
    add(1, 0, 0, 1, 0, 32'h500, 32'h100, 0, 0, 0);
    add(0, 0, 0, 0, 1, 32'h0,   32'h101, 0, 0, 1);
    add(1, 0, 0, 0, 0, 32'h0,   32'h100, 0, 0, 0);
    // tail call on a non-empty stack
    add(0, 0, 1, 0, 0, 32'h10,  32'h10,  0, 0, 0);
    add(0, 0, 0, 1, 0, 32'h30,  32'h30,  1, 0, 0);
    add(0, 0, 1, 0, 0, 32'h50,  32'h50,  1, 0, 0);
    add(0, 0, 0, 1, 1, 32'h90,  32'h90,  1, 0, 0);
    add(0, 0, 0, 0, 1, 32'h0,   32'h51,  0, 0, 0);
    // tail call on an empty stack acts as a push and underflows
    add(0, 0, 0, 1, 1, 32'h70,  32'h70,  1, 0, 1);
    add(0, 0, 0, 0, 1, 32'h0,   32'h52,  0, 0, 1);
    // reset overrides stall
    add(1, 1, 0, 0, 0, 32'h0,   32'h100, 0, 0, 0);

    // reset state
    @(posedge clk); @(posedge clk); #1;
    check("reset_pc",    pc_out,                32'h100);
    check("reset_seq",   pc_seq,                32'h101);
    check("reset_cnt",   {29'h0, ras_count},    32'h0);
    check("reset_empty", {31'h0, ras_empty},    32'h1);
    check("reset_full",  {31'h0, ras_full},     32'h0);
    check("reset_ovf",   {31'h0, ras_overflow}, 32'h0);
    check("reset_unf",   {31'h0, ras_underflow},32'h0);
    check("reset_pc8",   {24'h0, s8_pc_out},    32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst           = vecs[i].rst;
      stall         = vecs[i].stall;
      branch_taken  = vecs[i].br;
      call          = vecs[i].call;
      ret           = vecs[i].ret;
      branch_target = vecs[i].tgt;
      @(posedge clk); #1;
      check($sformatf("v%0d_pc", i),    pc_out,                 vecs[i].exp_pc);
      check($sformatf("v%0d_seq", i),   pc_seq,                 vecs[i].exp_pc + 32'd1);
      check($sformatf("v%0d_cnt", i),   {29'h0, ras_count},     {29'h0, vecs[i].exp_cnt});
      check($sformatf("v%0d_empty", i), {31'h0, ras_empty},     {31'h0, vecs[i].exp_cnt == 3'd0});
      check($sformatf("v%0d_full", i),  {31'h0, ras_full},      {31'h0, vecs[i].exp_cnt == 3'd4});
      check($sformatf("v%0d_ovf", i),   {31'h0, ras_overflow},  {31'h0, vecs[i].exp_ovf});
      check($sformatf("v%0d_unf", i),   {31'h0, ras_underflow}, {31'h0, vecs[i].exp_unf});
    end
    rst = 1'b0; stall = 0; branch_taken = 0; call = 0; ret = 0;

    // 8-bit wrap and stall sequence
    step8(0, 1, 8'hFC, 8'hFC, "w8_load");
    step8(0, 0, 8'h00, 8'h00, "w8_wrap");
    check("w8_ovf", {31'h0, s8_ovf}, 32'h0);
    check("w8_unf", {31'h0, s8_unf}, 32'h0);
    step8(0, 1, 8'h40, 8'h40, "w8_br40");
    step8(1, 0, 8'h00, 8'h40, "w8_stall1");
    step8(1, 0, 8'h00, 8'h40, "w8_stall2");
    step8(1, 0, 8'h00, 8'h40, "w8_stall3");
    step8(1, 1, 8'h10, 8'h40, "w8_stall_br");
    step8(0, 0, 8'h00, 8'h44, "w8_resume");
    check("w8_cnt", {29'h0, s8_count}, 32'h0);
    check("w8_q_drained", exp_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
